z32_ifetch: RTL

- Instruction fetch and prefetch stage directly upstream of the microcode sequencer.
- Fetches 32-bit instruction words over a req/ack memory port into a small prefetch queue.
- Presents the queue head as the IR: ir_opcode feeds the sequencer's dispatch, and ir_take is pulsed by the microinstruction that consumes the instruction.
- Handles branch redirects by flushing the queue and discarding any in-flight fetch.

---
 rtl/z32u_pkg.sv | 17 +
 rtl/z32_fetch_fifo.sv | 63 ++++++
 rtl/z32_ifetch.sv | 106 ++++++++++
 3 files changed

// File: rtl/z32u_pkg.sv
// Shared z32 front-end definitions: fetch queue defaults, opcode field
// position used by dispatch, and the prefetch queue entry layout.
package z32u_pkg;

  localparam int          FETCH_DEPTH = 2;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

  // Opcode field of an instruction word; the sequencer dispatch decodes the same bits.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/z32_fetch_fifo.sv
// Prefetch queue: circular FIFO of fetched words with their addresses.
// Flush empties it in one cycle; pops on an empty queue are dropped.
module z32_fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  z32u_pkg::fetch_entry_t     din,
  output z32u_pkg::fetch_entry_t     head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);
  import z32u_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop & (count != '0);
  assign valid  = (count != '0);
  // Empty queue presents zeros so the IR never shows a stale word.
  assign head   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/z32_ifetch.sv
// Instruction fetch/prefetch stage: one outstanding req/ack fetch feeding a
// small queue whose head is the IR; redirects flush and restart the stream.
module z32_ifetch #(
  parameter int          DEPTH    = z32u_pkg::FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = z32u_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ir_take,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [5:0]  ir_opcode,
  output logic [31:0] ir_pc,
  output logic        seq_stall
);
  import z32u_pkg::*;

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_ACK = 1'b1;

  logic [0:0]    state;
  logic [31:0]   fetch_pc;
  logic          discard;
  logic          outstanding;
  logic          ack_seen;
  logic          push;
  logic          pop;
  logic          issue;
  logic [CW-1:0] count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic          unused_pc_lsb;

  assign outstanding = (state == WAIT_ACK);
  assign mem_req     = outstanding;
  // An ack only counts against a live request; late acks after reset are ignored.
  assign ack_seen    = outstanding & mem_ack;
  assign push        = ack_seen & ~discard & ~redirect;
  assign pop         = ir_take & ~redirect;
  // Issue is held off during a redirect so the request targets the new pc.
  assign issue       = ~outstanding & ~redirect & (count < CNT_DEPTH);
  assign push_entry  = '{word: mem_rdata, pc: mem_addr};
  assign unused_pc_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
    end else begin
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (push) begin
        fetch_pc <= mem_addr + 32'd4;
      end

      case (state)
        IDLE: begin
          if (issue) begin
            state    <= WAIT_ACK;
            mem_addr <= fetch_pc;
          end
        end
        WAIT_ACK: begin
          // Requests are never aborted; a redirect only marks the reply stale.
          if (mem_ack) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
      endcase
    end
  end

  z32_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (push_entry),
    .head  (head),
    .valid (ir_valid),
    .count (count)
  );

  assign ir        = head.word;
  assign ir_pc     = head.pc;
  assign ir_opcode = head.word[OPC_MSB:OPC_LSB];
  assign seq_stall = ir_take & ~ir_valid;

endmodule
